// File: rtl/fp16_pkg.sv
// Shared types for the FP16 accumulation datapath: the operand type, the
// positive-zero constant the accumulator starts from, and the sequencer states.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_POS_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE
  } acc_state_t;

endpackage

// File: rtl/fp16_accumulator.sv
// Sequencer that folds a stream of FP16 operands into an accumulator using an
// external multi-cycle adder16 (acc + x), one addition in flight at a time.
module fp16_accumulator
  import fp16_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             add_en,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_z,
  input  logic             add_output_ready,
  output logic [15:0]      sum,
  output logic             done,
  output logic             busy,
  output logic             timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  acc_state_t        state;
  fp16_t             acc;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [WAIT_W-1:0] wait_cnt;

  assign cnt_inc = cnt + 1'b1;
  assign sum     = acc;

  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from pre-edge values; blocking '=' would let later
  // statements see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= FP16_POS_ZERO;
      len_q       <= '0;
      cnt         <= '0;
      wait_cnt    <= '0;
      add_a       <= FP16_POS_ZERO;
      add_b       <= FP16_POS_ZERO;
      in_ready    <= 1'b0;
      add_en      <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high during the done pulse, so a start there is dropped
          busy <= 1'b0;
          if (start && !busy) begin
            acc         <= FP16_POS_ZERO;
            cnt         <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (len != '0) begin
              len_q    <= len;
              in_ready <= 1'b1;
              state    <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end

        FETCH: begin
          if (in_valid && in_ready) begin
            add_a    <= acc;
            add_b    <= in_data;
            wait_cnt <= '0;
            in_ready <= 1'b0;
            add_en   <= 1'b1;
            state    <= WAIT;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A ready seen in the first WAIT cycle may be left over from the
          // previous addition, so only trust it from the second cycle on.
          if (wait_cnt != '0 && add_output_ready) begin
            acc    <= add_z;
            cnt    <= cnt_inc;
            add_en <= 1'b0;
            if (cnt_inc == len_q) begin
              state <= DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= FETCH;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            add_en      <= 1'b0;
            state       <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
